// File: rtl/sram_cfg_store.sv
// sram_cfg_store: settings shadow file backed by external async SRAM, with signature-checked preload and write-back engine
module sram_cfg_store #(
   parameter int          CFG_WORDS    = 4,
   parameter logic [17:0] BASE_ADDR    = 18'h00000,
   parameter logic [7:0]  SIG_VALUE    = 8'hA5,
   parameter logic [7:0]  DEFAULT_DIAL = 8'd123,
   parameter int          WAIT_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sram_we_n,
   input  logic [7:0]  sram_addr,
   input  logic [7:0]  sram_data_out,
   output logic [7:0]  sram_data_in,
   output logic        cfg_ready,
   output logic        busy,
   output logic [17:0] ext_addr,
   output logic [15:0] ext_dq_o,
   input  logic [15:0] ext_dq_i,
   output logic        ext_dq_oe,
   output logic        ext_ce_n,
   output logic        ext_oe_n,
   output logic        ext_we_n,
   output logic        ext_lb_n,
   output logic        ext_ub_n
);
   localparam int NB = CFG_WORDS + 1;
   localparam int IW = $clog2(NB);
   localparam int AW = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
   localparam int CW = $clog2(WAIT_CYCLES + 2);
   localparam logic [IW-1:0] LAST = IW'(CFG_WORDS);
   localparam logic [CW-1:0] WL   = CW'(WAIT_CYCLES);
   localparam logic [CW-1:0] WLM  = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] WLP  = CW'(WAIT_CYCLES + 1);
   localparam logic [7:0]    NW   = 8'(CFG_WORDS);

   typedef enum logic [2:0] {S_INIT, S_PRE, S_CHECK, S_FMT, S_IDLE, S_WRITE} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic [CW-1:0]   r_cnt;
   logic [NB-1:0]   r_dirty;
   logic [7:0]      r_sig;
   logic            r_ready;
   logic [7:0]      r_shadow [CFG_WORDS];

   logic            w_wr;
   logic            w_any;
   logic            w_unused;
   logic [AW-1:0]   w_a;
   logic [IW-1:0]   w_pick;
   logic [7:0]      w_wdata;
   logic [NB-1:0]   w_set;
   logic [NB-1:0]   w_clr;

   assign w_unused     = ^ext_dq_i[15:8];
   assign w_a          = sram_addr[AW-1:0];
   assign w_wr         = r_ready && !sram_we_n && sram_addr < NW;
   assign w_any        = |r_dirty;
   assign cfg_ready    = r_ready;
   assign ext_ub_n     = 1'b1;
   assign busy         = w_any || r_state == S_WRITE || r_state == S_FMT;
   assign sram_data_in = (r_ready && sram_addr < NW) ? r_shadow[w_a] : 8'h00;

   always_comb begin
      w_pick = '0;
      for (int i = NB - 1; i >= 0; i--)
         if (r_dirty[i]) w_pick = IW'(i);
      w_wdata = (w_pick == LAST) ? SIG_VALUE : r_shadow[w_pick[AW-1:0]];
      w_set   = w_wr ? (NB'(1) << w_a) : '0;
      w_clr   = ((r_state == S_IDLE || r_state == S_FMT) && w_any) ? (NB'(1) << w_pick) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_INIT;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_dirty   <= '0;
         r_sig     <= 8'h00;
         r_ready   <= 1'b0;
         for (int i = 0; i < CFG_WORDS; i++) r_shadow[i] <= 8'h00;
         ext_addr  <= '0;
         ext_dq_o  <= '0;
         ext_dq_oe <= 1'b0;
         ext_ce_n  <= 1'b1;
         ext_oe_n  <= 1'b1;
         ext_we_n  <= 1'b1;
         ext_lb_n  <= 1'b1;
      end else begin
         if (w_wr) r_shadow[w_a] <= sram_data_out;
         // a controller write in the pick cycle re-arms the same bit: set wins over clear
         r_dirty <= (r_dirty & ~w_clr) | w_set;
         case (r_state)
            S_INIT: begin
               r_state  <= S_PRE;
               r_idx    <= '0;
               r_cnt    <= '0;
               ext_addr <= BASE_ADDR;
               ext_ce_n <= 1'b0;
               ext_oe_n <= 1'b0;
               ext_lb_n <= 1'b0;
            end
            S_PRE: begin
               r_cnt <= (r_cnt == WLM) ? '0 : r_cnt + CW'(1);
               if (r_cnt == WLM && r_idx == LAST) begin
                  r_sig    <= ext_dq_i[7:0];
                  r_state  <= S_CHECK;
                  ext_ce_n <= 1'b1;
                  ext_oe_n <= 1'b1;
                  ext_lb_n <= 1'b1;
               end else if (r_cnt == WLM) begin
                  r_shadow[r_idx[AW-1:0]] <= ext_dq_i[7:0];
                  r_idx    <= r_idx + IW'(1);
                  ext_addr <= BASE_ADDR + 18'(r_idx) + 18'd1;
               end
            end
            S_CHECK: begin
               r_state <= (r_sig == SIG_VALUE) ? S_IDLE : S_FMT;
               r_ready <= r_sig == SIG_VALUE;
               if (r_sig != SIG_VALUE) begin
                  for (int i = 0; i < CFG_WORDS; i++)
                     r_shadow[i] <= (i == CFG_WORDS - 1) ? DEFAULT_DIAL : 8'h00;
                  r_dirty <= '1;
               end
            end
            S_IDLE, S_FMT: begin
               if (w_any) begin
                  r_state   <= S_WRITE;
                  r_cnt     <= '0;
                  ext_addr  <= BASE_ADDR + 18'(w_pick);
                  ext_dq_o  <= {8'h00, w_wdata};
                  ext_dq_oe <= 1'b1;
                  ext_ce_n  <= 1'b0;
                  ext_lb_n  <= 1'b0;
               end else if (r_state == S_FMT) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            S_WRITE: begin
               r_cnt <= r_cnt + CW'(1);
               // r_cnt is the phase of the current cycle: 0 setup, 1..WAIT strobe, WAIT+1 hold
               if (r_cnt == WLP) begin
                  r_state   <= r_ready ? S_IDLE : S_FMT;
                  ext_dq_oe <= 1'b0;
                  ext_ce_n  <= 1'b1;
                  ext_lb_n  <= 1'b1;
                  ext_we_n  <= 1'b1;
               end else begin
                  ext_we_n <= r_cnt == WL;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end
endmodule

// File: doc/sram_cfg_store.md
# sram_cfg_store

Responder for the safe controller's single-cycle settings-memory port: returns read data for addresses 0–3 combinationally from a shadow register file and accepts one-cycle active-low write strobes. Behind the shadow file, the block owns the external 16-bit asynchronous SRAM:
- At reset it preloads the shadow file from SRAM, validated by a signature byte.
- It posts every write back to SRAM with a multi-cycle write engine.
- The top level holds the controller in reset until `cfg_ready` is asserted.

## Interface
- `CFG_WORDS`, 4: shadowed bytes; addr 0..2 = op1..op3 (bit0), addr 3 = dial target.
- `BASE_ADDR`, 18'h00000: external word address of shadow byte 0; signature at `BASE_ADDR+CFG_WORDS`.
- `SIG_VALUE`, 8'hA5: signature byte.
- `DEFAULT_DIAL`, 8'd123: dial default written on blank SRAM (op defaults 0).
- `WAIT_CYCLES`, 2: access cycles per external read / WE_n-low cycles per write (≥1).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `sram_we_n`  in  1  controller write strobe, low = write this cycle.
- `sram_addr`  in  8  controller address.
- `sram_data_out`  in  8  controller write data.
- `sram_data_in`  out  8  read data to controller (combinational).
- `cfg_ready`  out  1  preload finished; controller may run.
- `busy`  out  1  any dirty byte pending or external write in progress.
- `ext_addr`  out  18  external SRAM word address.
- `ext_dq_o`  out  16  write data, `{8'h00, byte}`.
- `ext_dq_i`  in  16  read data; bits [7:0] used.
- `ext_dq_oe`  out  1  tri-state enable for DQ (top drives pad).
- `ext_ce_n`, `ext_oe_n`, `ext_we_n`, `ext_lb_n`, `ext_ub_n`  out  1 each  SRAM controls, active-low; `ext_ub_n` always 1 except in reset (1).

## Operation
- The state machine runs `PRELOAD` → `CHECK` → (`FORMAT`) → `IDLE` ⇄ `WRITE`.
- **Shadow file:** `CFG_WORDS` × 8-bit registers, reset to 0.
  - `sram_data_in = shadow[sram_addr]` if `sram_addr < CFG_WORDS` and `cfg_ready`; otherwise 8'h00.
- **PRELOAD:** reads indices 0..`CFG_WORDS` (signature last).
  - Each index holds `ext_addr = BASE_ADDR+i`, `ce_n=oe_n=lb_n=0`, `dq_oe=0` for `WAIT_CYCLES` cycles.
  - `ext_dq_i[7:0]` is sampled on the edge ending the last cycle, into `shadow[i]` or a signature register.
- **CHECK (1 cycle):**
  - If the signature equals `SIG_VALUE`, go to IDLE.
  - Otherwise go to FORMAT: shadow loads defaults `{0,0,0,DEFAULT_DIAL}` and all indices plus the signature are marked dirty.
- **FORMAT:** drains dirty entries with the write engine (lowest index first, signature last), then goes to IDLE.
- `cfg_ready` rises on the cycle IDLE is first entered and stays high until reset.
- **Controller writes:** accepted only when `cfg_ready`.
  - Any cycle with `sram_we_n==0` and `sram_addr<CFG_WORDS` updates `shadow[addr]` at that edge and sets `dirty[addr]`.
  - Addresses ≥ `CFG_WORDS` are ignored.
  - A strobe held low N cycles counts as N identical writes.
  - Writes arriving before `cfg_ready` are dropped.
- **IDLE:** if any dirty bit is set, pick the lowest dirty index, latch its shadow byte into the write-data register, clear that dirty bit and enter WRITE.
  - A controller write to the same index in the same cycle re-sets dirty; set wins over clear.
- **WRITE:** `WAIT_CYCLES+2` cycles.
  - Setup (1 cycle): addr/data driven, `dq_oe=1`, `ce_n=lb_n=0`, `we_n=1`, `oe_n=1`.
  - `WAIT_CYCLES` cycles with `we_n=0`.
  - Hold (1 cycle): `we_n=1`, data still driven.
  - Then return to IDLE.
- `busy = |dirty` or state ∈ {WRITE, FORMAT}.
- **Reset mid-operation:**
  - All external controls go inactive immediately (asynchronous).
  - Dirty bits and `cfg_ready` clear, and preload restarts after deassertion.
  - An interrupted write is lost.

## Timing
- **Reset values:**
  - `ext_ce_n=ext_oe_n=ext_we_n=ext_lb_n=ext_ub_n=1`.
  - `ext_dq_oe=0`, `ext_addr=0`, `ext_dq_o=0`.
  - `cfg_ready=0`, `busy=0`, `sram_data_in=0`.
- Read latency to the controller: 0 cycles, combinational from the registered shadow.
- Write visibility: a strobe at edge k is readable from cycle k+1.
- Preload: `(CFG_WORDS+1)·WAIT_CYCLES` cycles, plus 1 for CHECK.
  - Valid SRAM, defaults: 10+1 cycles, so `cfg_ready` rises on the 12th edge after reset release.
- Flush start: a dirty bit set at edge k enters WRITE at edge k+1 if IDLE; `ext_we_n` falls at edge k+2.
- External outputs are registered and glitch-free. DQ is never driven while `ext_oe_n=0`.

## Test plan
- **Valid preload:** SRAM model holds {01,00,01,C8,A5} → after 11 cycles `cfg_ready=1`; addr 0..3 read 01,00,01,C8; addr 7 reads 00; no `ext_we_n` activity.
- **Blank SRAM:** all FF → shadow reads 00,00,00,7B; 5 writes observed (indices 0..3 then signature A5), each 4 cycles; `cfg_ready` only after the last; model then holds defaults.
- **Admin write:** one-cycle strobe addr 3 data 8'h40 → next cycle reads 40; `busy` high; one write to `BASE_ADDR+3` with `we_n` low exactly 2 cycles and DQ=0x0040; `busy` low after.
- **Back-to-back writes:** strobes to addr 0 then 2 on consecutive cycles → flushed in order 0, 2 with no gap beyond one IDLE cycle.
- **Rewrite during flush:** write addr 1=01, then addr 1=00 during that flush → two external writes, final SRAM value 00.
- **Reset mid-write:** assert `rst` during `we_n` low → all ext controls 1 and `dq_oe` 0 the same cycle; after release, preload re-runs and `cfg_ready` re-asserts.
